left_barrel_rotator_seq: RTL and testbench
==========================================

# left_barrel_rotator_seq

Sequential 8-bit left barrel rotator with valid/ready handshakes on both sides. It is the inverse companion of the combinational right barrel shifter: it rotates `d` left by `s` positions, so a word rotated by this block and then right-rotated by the same `s` returns the original word. It resolves one power-of-two rotate stage per clock (MSB amount first) and sits between a producer and a consumer that both follow valid/ready flow control.

## Interface
- `WIDTH`, 8, data width; must be a power of two, at least 2.
- `SHIFT_W`, $clog2(WIDTH), rotate-amount width and number of stage cycles; derived, not overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer presents `d`/`s`.
- `in_ready`  out  1  block can accept a word.
- `d`  in  WIDTH  word to rotate.
- `s`  in  SHIFT_W  left-rotate amount, 0..WIDTH-1.
- `out_valid`  out  1  `q` holds a finished result.
- `out_ready`  in  1  consumer accepts `q`.
- `q`  out  WIDTH  rotated result.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: capture `d` into `data_r` and `s` into `amt_r`; set `cnt` to SHIFT_W-1; go to SHIFT.
- SHIFT:
  - Each cycle, if `amt_r[cnt]`=1, `data_r` <= `data_r` rotated left by 2^cnt; otherwise `data_r` holds.
  - When `cnt`==0, go to DONE. Otherwise decrement `cnt`.
- DONE:
  - `out_valid`=1 and `q`=`data_r`.
  - On `out_ready`, go to IDLE.
  - `q` and `out_valid` stay stable while `out_ready`=0.
- Rotation is lossless: bits leaving the MSB re-enter at the LSB. No zero fill, no sign fill.
- Handshake rules:
  - `in_ready`, `out_valid` and `busy` are pure decodes of the state.
  - `in_ready` is 0 in SHIFT and DONE. No new word is accepted during the same cycle as an output handshake.
- `s`=0 still passes through every SHIFT cycle; the word comes out unchanged.
- `d`/`s` changes while `in_ready`=0 are ignored.
- An `out_ready` pulse outside DONE has no effect.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, `data_r`=0, `amt_r`=0, `cnt`=0.
  - Outputs: `q`=0, `out_valid`=0, `busy`=0, `in_ready`=1.
- Reset mid-operation: the in-flight word is discarded with no output, and the block is in IDLE on the first edge after release.
- Latency: `out_valid` rises SHIFT_W rising edges after the accepting edge, i.e. 3 edges for WIDTH=8.
- Throughput: at best one word every SHIFT_W+2 cycles (5 for WIDTH=8), reached when `out_ready` is held high.
- Back-to-back: the earliest next `in_valid` acceptance is the edge after the output handshake edge.

## Structure
- Package `rotator_pkg`:
  - state enum `rot_state_t` (IDLE, SHIFT, DONE);
  - default width constant `ROT_WIDTH`=8.
- Sub-module `rotl_pow2_stage`:
  - combinational;
  - inputs: data, a stage index, an enable;
  - output: data rotated left by 2^index when enabled, otherwise data unchanged;
  - built from the existing `mux_2x1` cells, one per bit.
- Top level: FSM, counter, data/amount registers, one `rotl_pow2_stage` instance.

## Test plan
- `d`=0x81, `s`=1, `out_ready`=1 → `q`=0x03 with `out_valid` exactly 3 edges after acceptance, then IDLE.
- `d`=0xB4, `s`=4 → `q`=0x4B. Then `d`=0x01, `s`=7 → `q`=0x80. Then `d`=0x5A, `s`=0 → `q`=0x5A.
- Backpressure: `d`=0x96, `s`=3, `out_ready`=0 for 10 cycles → `q`=0xB4 stable, `out_valid` held high, `in_ready`=0 throughout. Release `out_ready` → one handshake, then `in_ready`=1.
- Reset mid-SHIFT: deassert `rst_n` one edge after accepting 0xFF/`s`=2 → all outputs return to reset values, no `out_valid` pulse. After release, new word 0x0F/`s`=4 → `q`=0xF0.
- Exhaustive round trip: every `d` in 0..255 and every `s` in 0..7, streamed with `in_valid`/`out_ready` randomized → `q` equals the golden rotate-left result. Feeding `q` and `s` into the combinational right barrel shifter returns the original `d` for every case.
- Continuous streaming with `in_valid`=1 and `out_ready`=1 → exactly one result every 5 cycles, in order, with no drops or duplicates.

Source files
------------

// File: rtl/left_barrel_rotator_seq_pkg.sv
// Shared types and defaults for the sequential left barrel rotator.
package rotator_pkg;

    localparam int ROT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rot_state_t;

endpackage

// File: rtl/left_barrel_rotator_seq_if.sv
// Producer/consumer handshake bundle for the left barrel rotator.
interface left_barrel_rotator_seq_if
    import rotator_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH
);
    localparam int SHIFT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   d;
    logic [SHIFT_W-1:0] s;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   q;
    logic               busy;

    modport slave (
        input  in_valid, d, s, out_ready,
        output in_ready, out_valid, q, busy
    );

    modport master (
        output in_valid, d, s, out_ready,
        input  in_ready, out_valid, q, busy
    );

endinterface

// File: rtl/left_barrel_rotator_seq_stage.sv
// One power-of-two left-rotate stage built from per-bit 2:1 mux cells.
module mux_2x1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);
    assign o_y = i_sel ? i_b : i_a;
endmodule

module rotl_pow2_stage #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_data
);
    logic [IDX_W:0]     w_amt;
    logic [WIDTH-1:0]   w_rot;

    // 2^idx never exceeds WIDTH/2, so both shift terms stay in range.
    assign w_amt = (IDX_W+1)'(1) << i_idx;
    assign w_rot = (i_data << w_amt) | (i_data >> ((IDX_W+1)'(WIDTH) - w_amt));

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux_2x1 u_mux (
            .i_a   (i_data[i]),
            .i_b   (w_rot[i]),
            .i_sel (i_en),
            .o_y   (o_data[i])
        );
    end
endmodule

// File: rtl/left_barrel_rotator_seq.sv
// Sequential left barrel rotator: one power-of-two stage per clock, MSB amount first.
//  state | meaning
//  IDLE  | ready for a new word
//  SHIFT | applying stage cnt, counting down to 0
//  DONE  | result on q, waiting for out_ready
module left_barrel_rotator_seq
    import rotator_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    left_barrel_rotator_seq_if.slave rot
);
    localparam int SHIFT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_data;
    logic [SHIFT_W-1:0] r_amt;
    logic [SHIFT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   w_stage;
    logic               w_en;

    assign w_en = r_amt[r_cnt];

    rotl_pow2_stage #(
        .WIDTH (WIDTH),
        .IDX_W (SHIFT_W)
    ) u_stage (
        .i_data (r_data),
        .i_idx  (r_cnt),
        .i_en   (w_en),
        .o_data (w_stage)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_amt   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rot.in_valid) begin
                        r_data  <= rot.d;
                        r_amt   <= rot.s;
                        r_cnt   <= SHIFT_W'(SHIFT_W - 1);
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_data <= w_stage;
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (rot.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rot.in_ready  = (r_state == S_IDLE);
    assign rot.out_valid = (r_state == S_DONE);
    assign rot.busy      = (r_state != S_IDLE);
    assign rot.q         = r_data;

endmodule

// File: tb/tb_left_barrel_rotator_seq.sv
// Scoreboard bench for left_barrel_rotator_seq: driver queues expectations, monitor checks handshakes.
module tb_left_barrel_rotator_seq;
    import rotator_pkg::*;

    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic [7:0] q;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    left_barrel_rotator_seq_if #(.WIDTH(8)) bus ();

    left_barrel_rotator_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rot   (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   or_mode = 1;
    bit   stream_mode = 1'b0;
    int   last_hs = -1;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] d, input int s);
        logic [15:0] w;
        w = {d, d} << s;
        return w[15:8];
    endfunction

    // Independent right barrel shifter used for the round-trip check.
    function automatic logic [7:0] rotr8(input logic [7:0] q, input int s);
        logic [15:0] w;
        w = {q, q} >> s;
        return w[7:0];
    endfunction

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got q=%0h expected no output", bus.q);
            end else begin
                mon_e = sb.pop_front();
                chk("q", 32'(bus.q), 32'(mon_e.q));
                chk("roundtrip", 32'(rotr8(bus.q, int'(mon_e.s))), 32'(mon_e.d));
                if (stream_mode) begin
                    if (last_hs >= 0) chk("stream_interval", 32'(cyc - last_hs), 32'd5);
                    last_hs = cyc;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [7:0] q, input bit keep);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.d = d;
        bus.s = s;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 (d=%0h)", d);
        end else begin
            e.d = d;
            e.s = s;
            e.q = q;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.d = '0;
        bus.s = '0;
        #12;
        chk("rst_q", 32'(bus.q), 32'h00);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First word with latency measurement
        send(8'h81, 3'd1, 8'h03, 1'b0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.out_valid) break;
        end
        chk("latency", 32'(n), 32'd3);
        drain();
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        send(8'hB4, 3'd4, 8'h4B, 1'b0);
        send(8'h01, 3'd7, 8'h80, 1'b0);
        send(8'h5A, 3'd0, 8'h5A, 1'b0);
        drain();

        // Backpressure
        or_mode = 0;
        repeat (2) @(posedge clk);
        #2;
        send(8'h96, 3'd3, 8'hB4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_q", 32'(bus.q), 32'hB4);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_busy", 32'(bus.busy), 32'd1);
        end
        or_mode = 1;
        drain();
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);

        // Reset while in SHIFT
        send(8'hFF, 3'd2, 8'hFF, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mrst_q", 32'(bus.q), 32'h00);
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mrst_hold_out_valid", 32'(bus.out_valid), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(8'h0F, 3'd4, 8'hF0, 1'b0);
        drain();

        // Exhaustive sweep with randomized flow control
        or_mode = 2;
        for (int dv = 0; dv < 256; dv++) begin
            for (int sv = 0; sv < 8; sv++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send(8'(dv), 3'(sv), rotl8(8'(dv), sv), 1'b0);
            end
        end
        drain();

        // Continuous streaming
        or_mode = 1;
        repeat (2) @(posedge clk);
        #2;
        stream_mode = 1'b1;
        last_hs = -1;
        send(8'h12, 3'd1, 8'h24, 1'b1);
        send(8'h80, 3'd1, 8'h01, 1'b1);
        send(8'hF0, 3'd2, 8'hC3, 1'b1);
        send(8'h3C, 3'd3, 8'hE1, 1'b1);
        send(8'hA5, 3'd5, 8'hB4, 1'b1);
        send(8'h01, 3'd6, 8'h40, 1'b1);
        send(8'hC0, 3'd7, 8'h60, 1'b1);
        send(8'h55, 3'd1, 8'hAA, 1'b0);
        drain();
        stream_mode = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
